// File: rtl/piso_shift_register.sv
// ---------------------------------------------------------------------------
// piso_shift_register
//
// Parallel-in serial-out shift register. A WIDTH-bit word is captured on a
// load strobe and then shifted out one bit per clock. Shifting is
// free-running while load is low. Once the word has been fully shifted out,
// the register holds only FILL_BIT, and serial_out keeps showing FILL_BIT
// until the next load.
//
// Configuration macro:
//   PISO_LSB_FIRST_EN  undefined (default): MSB first, serial_out = shreg[WIDTH-1]
//                      defined            : LSB first, serial_out = shreg[0]
//
// Parameters:
//   WIDTH     word width in bits (must be >= 2)
//   FILL_BIT  value shifted into the vacated end on each shift
//
// Ports:
//   clk         in   1      clock, all state updates on rising edge
//   rst         in   1      asynchronous active-high reset, clears the register
//   load        in   1      parallel load strobe, has priority over shifting
//   p           in   WIDTH  parallel data word, sampled when load = 1
//   serial_out  out  1      output-end bit of the shift register
// ---------------------------------------------------------------------------
module piso_shift_register #(
    parameter int   WIDTH    = 4,
    parameter logic FILL_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] p,
    output logic             serial_out
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Next-state selection: load wins, otherwise shift toward the output end
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = p;
        end else begin
`ifdef PISO_LSB_FIRST_EN
            shreg_d = {FILL_BIT, shreg_q[WIDTH-1:1]};
`else
            shreg_d = {shreg_q[WIDTH-2:0], FILL_BIT};
`endif
        end
    end

    // Shift register state, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // serial_out is taken straight from a flop. There is no path from p or load.
`ifdef PISO_LSB_FIRST_EN
    assign serial_out = shreg_q[0];
`else
    assign serial_out = shreg_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_piso_shift_register.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_register
//
// Scoreboard bench. When a word is loaded, its bits are pushed in the
// expected output order. Each sample after a rising edge pops one expected
// bit. An empty queue means the register is exhausted, so the expected
// value is FILL.
// ---------------------------------------------------------------------------
module tb_piso_shift_register #(
    parameter logic FILL = 1'b0
);
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] p;
    logic         serial_out;

    logic exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    piso_shift_register #(
        .WIDTH   (W),
        .FILL_BIT(FILL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .p         (p),
        .serial_out(serial_out)
    );

    always #5 clk = ~clk;

    // Bit k of word w in the order it should appear on serial_out
    function automatic logic out_bit(input logic [W-1:0] w, input int k);
`ifdef PISO_LSB_FIRST_EN
        return w[k];
`else
        return w[W-1-k];
`endif
    endfunction

    function automatic logic next_exp();
        if (exp_q.size() > 0) return exp_q.pop_front();
        return FILL;
    endfunction

    // After reset the zero word is already presenting its first bit.
    // W-1 further zeros follow before fill bits appear.
    task automatic seed_after_reset();
        exp_q.delete();
        for (int k = 0; k < W - 1; k++) exp_q.push_back(1'b0);
    endtask

    // Drive one cycle between edges, then return #1 after the rising edge
    task automatic drive(input logic ld, input logic [W-1:0] w);
        @(negedge clk);
        load = ld;
        p    = w;
        if (ld) begin
            exp_q.delete();
            for (int k = 0; k < W; k++) exp_q.push_back(out_bit(w, k));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic e;
        rst  = 1'b1;
        load = 1'b1;
        p    = 4'b1111;
        #1;
        n_cmp++;
        if (serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: serial_out=%b required=0", serial_out);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (serial_out !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: serial_out=%b required=0", i, serial_out);
            end
        end
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        seed_after_reset();
        for (int i = 0; i < W + 1; i++) begin
            drive(1'b0, W'($urandom));
            e = next_exp();
            n_cmp++;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: serial_out=%b required=%b", i, serial_out, e);
            end
        end
    endtask

    task automatic test_basic();
        logic e;
        drive(1'b1, 4'b1001);
        for (int i = 0; i < W + 3; i++) begin
            if (i > 0) drive(1'b0, W'($urandom));
            e = next_exp();
            n_cmp++;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL basic[%0d]: serial_out=%b required=%b", i, serial_out, e);
            end
        end
    endtask

    task automatic test_reload_mid_word();
        logic e;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       drive(1'b1, 4'b1100);
                2:       drive(1'b1, 4'b0011);
                default: drive(1'b0, W'($urandom));
            endcase
            e = next_exp();
            n_cmp++;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL reload[%0d]: serial_out=%b required=%b", i, serial_out, e);
            end
        end
    endtask

    task automatic test_continuous_load();
        logic       e;
        logic [W-1:0] words [3] = '{4'b1010, 4'b0110, 4'b1000};
        for (int i = 0; i < 3 + W + 1; i++) begin
            if (i < 3) drive(1'b1, words[i]);
            else       drive(1'b0, W'($urandom));
            e = next_exp();
            n_cmp++;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL continuous[%0d]: serial_out=%b required=%b", i, serial_out, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic e;
        drive(1'b1, 4'b1011);
        drive(1'b0, 4'b0000);
        e = out_bit(4'b1011, 1);
        n_cmp++;
        if (serial_out !== e) begin
            n_fail++;
            $display("FAIL arst_pre: serial_out=%b required=%b", serial_out, e);
        end
        // Assert reset between edges; the output must clear without a clock
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: serial_out=%b required=0", serial_out);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_hold: serial_out=%b required=0", serial_out);
        end
        @(negedge clk);
        rst = 1'b0;
        seed_after_reset();
        for (int i = 0; i < W + 1; i++) begin
            drive(1'b0, W'($urandom));
            e = next_exp();
            n_cmp++;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL arst_release[%0d]: serial_out=%b required=%b", i, serial_out, e);
            end
        end
        for (int i = 0; i < W + 1; i++) begin
            if (i == 0) drive(1'b1, 4'b0110);
            else        drive(1'b0, W'($urandom));
            e = next_exp();
            n_cmp++;
            if (serial_out !== e) begin
                n_fail++;
                $display("FAIL arst_reload[%0d]: serial_out=%b required=%b", i, serial_out, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < W; i++) begin
                if (i == 0) drive(1'b1, W'($urandom));
                else        drive(1'b0, W'($urandom));
                e = next_exp();
                n_cmp++;
                if (serial_out !== e) begin
                    n_fail++;
                    $display("FAIL b2b[%0d.%0d]: serial_out=%b required=%b", w, i, serial_out, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload_mid_word();
        test_continuous_load();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
